// File: rtl/gmii_rx_frame_buffer_pkg.sv
// Shared Ethernet receive constants, FSM state type and helpers for the GMII receive frame buffer.
package xvc_eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam int          ETH_FCS_BYTES = 4;
    localparam int          FRAME_LEN_W   = 12;

    typedef logic [FRAME_LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_PAYLOAD,
        RX_DROP
    } rx_state_t;

    // The shift-right CRC register holds the residue bit-reversed relative to CRC32_RESIDUE.
    function automatic logic [31:0] reflect32(input logic [31:0] value);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            result[i] = value[31-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/gmii_rx_frame_buffer_if.sv
// Output byte stream from the frame buffer to the driver: valid/ready with a last-byte marker.
interface gmii_rx_frame_buffer_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/gmii_rx_frame_buffer_crc32_d8.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (LSB-first, polynomial 0xEDB88320).
module crc32_d8
    import xvc_eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        // NOTE: blocking assignments chain the eight bit-steps inside one combinational evaluation.
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/gmii_rx_frame_buffer.sv
// Store-and-forward GMII receive buffer: strips preamble/SFD/FCS, releases only good frames.
// Optional CRC-32 residue check is compiled in when RX_CRC_CHECK_EN is defined.
module gmii_rx_frame_buffer
    import xvc_eth_pkg::*;
#(
    parameter int DATA_DEPTH = 2048,
    parameter int LEN_DEPTH  = 8,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    sgmii_rxd,
    input  logic                          sgmii_rx_dv,
    input  logic                          sgmii_rx_er,
    gmii_rx_frame_buffer_if.master        stream,
    output logic [15:0]                   frames_ok,
    output logic [15:0]                   frames_drop
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int LW = $clog2(LEN_DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef logic [LW:0] lptr_t;

    localparam ptr_t  PTR_ONE  = ptr_t'(1);
    localparam ptr_t  PTR_FCS  = ptr_t'(ETH_FCS_BYTES);
    localparam lptr_t LPTR_ONE = lptr_t'(1);
    localparam len_t  LEN_ONE  = len_t'(1);
    localparam len_t  LEN_FCS  = len_t'(ETH_FCS_BYTES);
    localparam len_t  MIN_LEN  = len_t'(MIN_FRAME);
    localparam len_t  MAX_LEN  = len_t'(MAX_FRAME);

    rx_state_t state, state_next;

    ptr_t  wr_ptr, commit_ptr, rd_ptr;
    len_t  len;
    logic  ovf;

    logic  wr_byte, sof, eof, abort;
    logic  ram_full, wr_ok, frame_good, commit, rollback, crc_ok;

    logic [7:0] mem [DATA_DEPTH];
    logic [7:0] ram_q;

    len_t  len_fifo [LEN_DEPTH];
    lptr_t lf_wr, lf_rd;
    logic  lf_full, lf_empty;
    len_t  head, cur, rem;
    logic  busy, advance, load;
    logic  out_valid, out_last;

    // ---------------------------------------------------------------- receive FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        state_next = state;
        wr_byte    = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        abort      = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (sgmii_rx_dv) begin
                    state_next = (!sgmii_rx_er && sgmii_rxd == ETH_PREAMBLE) ? RX_PREAMBLE : RX_DROP;
                end
            end
            RX_PREAMBLE: begin
                if (!sgmii_rx_dv) begin
                    state_next = RX_IDLE;
                end else if (sgmii_rx_er || (sgmii_rxd != ETH_PREAMBLE && sgmii_rxd != ETH_SFD)) begin
                    state_next = RX_DROP;
                    abort      = 1'b1;
                end else if (sgmii_rxd == ETH_SFD) begin
                    state_next = RX_PAYLOAD;
                    sof        = 1'b1;
                end
            end
            RX_PAYLOAD: begin
                if (!sgmii_rx_dv) begin
                    state_next = RX_IDLE;
                    eof        = 1'b1;
                end else if (sgmii_rx_er) begin
                    state_next = RX_DROP;
                    abort      = 1'b1;
                end else begin
                    wr_byte = 1'b1;
                end
            end
            RX_DROP: begin
                if (!sgmii_rx_dv) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- optional CRC check
`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc, crc_next;

    crc32_d8 u_crc32_d8 (
        .crc      (crc),
        .data     (sgmii_rxd),
        .crc_next (crc_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc <= CRC32_INIT;
        end else if (sof) begin
            crc <= CRC32_INIT;
        end else if (wr_byte) begin
            crc <= crc_next;
        end
    end

    assign crc_ok = (reflect32(crc) == CRC32_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    // ---------------------------------------------------------------- write side / commit
    assign ram_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok      = wr_byte && !ovf && !ram_full;
    assign frame_good = (len >= MIN_LEN) && (len <= MAX_LEN) && !ovf && !lf_full && crc_ok;
    assign commit     = eof && frame_good;
    assign rollback   = abort || (eof && !frame_good);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            len         <= '0;
            ovf         <= 1'b0;
            lf_wr       <= '0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            if (sof) begin
                len <= '0;
                ovf <= 1'b0;
            end
            if (wr_byte) begin
                if (len != '1) begin
                    len <= len + LEN_ONE;
                end
                if (ram_full) begin
                    ovf <= 1'b1;
                end
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
            end
            // The FCS bytes are released back so the next frame overwrites them.
            if (commit) begin
                wr_ptr     <= wr_ptr - PTR_FCS;
                commit_ptr <= wr_ptr - PTR_FCS;
                lf_wr      <= lf_wr + LPTR_ONE;
                frames_ok  <= frames_ok + 16'd1;
            end
            if (rollback) begin
                wr_ptr      <= commit_ptr;
                frames_drop <= frames_drop + 16'd1;
            end
        end
    end

    // NOTE: RAM and length storage have no reset; pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= sgmii_rxd;
        end
        if (load) begin
            ram_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            len_fifo[lf_wr[LW-1:0]] <= len - LEN_FCS;
        end
    end

    // ---------------------------------------------------------------- read side
    // The head entry stays in the length FIFO until its last byte is fetched.
    assign lf_empty = (lf_wr == lf_rd);
    assign lf_full  = (lf_wr[LW] != lf_rd[LW]) && (lf_wr[LW-1:0] == lf_rd[LW-1:0]);
    assign head     = len_fifo[lf_rd[LW-1:0]];
    assign cur      = busy ? rem : head;
    assign advance  = !out_valid || stream.out_ready;
    assign load     = advance && !lf_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            rem       <= '0;
            rd_ptr    <= '0;
            lf_rd     <= '0;
        end else if (advance) begin
            out_valid <= !lf_empty;
            out_last  <= load && (cur == LEN_ONE);
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                if (cur == LEN_ONE) begin
                    busy  <= 1'b0;
                    lf_rd <= lf_rd + LPTR_ONE;
                end else begin
                    busy <= 1'b1;
                    rem  <= cur - LEN_ONE;
                end
            end
        end
    end

    assign stream.out_valid = out_valid;
    assign stream.out_last  = out_last;
    assign stream.out_data  = out_valid ? ram_q : 8'h00;

endmodule

// File: tb/tb_gmii_rx_frame_buffer.sv
// Scoreboard bench for gmii_rx_frame_buffer: good, errored, runt, oversize, bad-FCS, FIFO-full and reset frames.
module tb_gmii_rx_frame_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rxd   = 8'h00;
    logic        dv    = 1'b0;
    logic        er    = 1'b0;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;

    gmii_rx_frame_buffer_if stream_if ();

    gmii_rx_frame_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .sgmii_rxd   (rxd),
        .sgmii_rx_dv (dv),
        .sgmii_rx_er (er),
        .stream      (stream_if),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          last_cnt = 0;
    int          exp_ok   = 0;
    int          exp_drop = 0;
    logic [11:0] exp_wr_ptr = '0;
    bit          crc_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        tick();
        rxd = d;
        dv  = v;
        er  = e;
    endtask

    // n data bytes (DA onward) plus a computed FCS; er_idx < 0 means no error byte.
    task automatic send_frame(input int n, input int base, input int er_idx, input bit bad_fcs, input bit pass);
        logic [7:0]  fr[$];
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            fr.push_back(8'(base + i));
            c = crc_byte(c, fr[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            fr.push_back(c[8*k +: 8]);
        end
        if (bad_fcs) begin
            fr[n] = fr[n] ^ 8'h01;
        end
        if (pass) begin
            for (int i = 0; i < n; i++) begin
                sb_q.push_back('{data: fr[i], last: (i == n - 1)});
            end
            exp_ok++;
            exp_wr_ptr = exp_wr_ptr + 12'(n);
        end else begin
            exp_drop++;
        end
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            drive(fr[i], 1'b1, (i == er_idx));
        end
        repeat (12) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < max_cycles) begin
            tick();
            cyc++;
        end
        repeat (4) tick();
        check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(stream_if.out_valid), 32'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frames_ok"}, 32'(frames_ok), 32'(exp_ok));
        check({tag, "_frames_drop"}, 32'(frames_drop), 32'(exp_drop));
    endtask

    // Output monitor: every valid cycle is compared with the scoreboard head, stalled or not.
    always @(negedge clock) begin
        if (reset && stream_if.out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(stream_if.out_valid), 32'd0);
            end else begin
                check("out_data", 32'(stream_if.out_data), 32'(sb_q[0].data));
                check("out_last", 32'(stream_if.out_last), 32'(sb_q[0].last));
                if (stream_if.out_ready) begin
                    void'(sb_q.pop_front());
                    if (stream_if.out_last) begin
                        last_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the run completed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_before;
`ifdef RX_CRC_CHECK_EN
        crc_en = 1'b1;
`else
        crc_en = 1'b0;
`endif
        stream_if.out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(stream_if.out_valid), 32'd0);
        check("rst_last", 32'(stream_if.out_last), 32'd0);
        check("rst_data", 32'(stream_if.out_data), 32'd0);
        check_counters("rst");
        reset = 1'b1;
        repeat (2) tick();

        // 1: good 60-byte payload frame
        send_frame(60, 8'h00, -1, 1'b0, 1'b1);
        wait_drain("t1", 2000);
        check_counters("t1");
        check("t1_last_count", 32'(last_cnt), 32'd1);
        check("t1_wr_ptr", 32'(dut.wr_ptr), 32'(exp_wr_ptr));

        // 2: rx_er on payload byte 20
        send_frame(60, 8'h00, 20, 1'b0, 1'b0);
        wait_drain("t2", 200);
        check_counters("t2");
        check("t2_wr_ptr", 32'(dut.wr_ptr), 32'(exp_wr_ptr));

        // 3: runt, oversize, then a good frame
        send_frame(36, 8'h40, -1, 1'b0, 1'b0);
        send_frame(1596, 8'h00, -1, 1'b0, 1'b0);
        check_counters("t3_drops");
        check("t3_wr_ptr", 32'(dut.wr_ptr), 32'(exp_wr_ptr));
        send_frame(60, 8'h80, -1, 1'b0, 1'b1);
        wait_drain("t3", 2000);
        check_counters("t3");

        // 4: single FCS bit flipped
        send_frame(60, 8'hC0, -1, 1'b1, !crc_en);
        wait_drain("t4", 2000);
        check_counters("t4");

        // 5: stalled output, nine frames into an eight-entry length FIFO
        stream_if.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            send_frame(60, k * 16 + 3, -1, 1'b0, (k < 8));
        end
        check_counters("t5_stalled");
        check("t5_stall_valid", 32'(stream_if.out_valid), 32'd1);
        last_before = last_cnt;
        tick();
        stream_if.out_ready = 1'b1;
        wait_drain("t5", 4000);
        check("t5_last_count", 32'(last_cnt - last_before), 32'd8);
        check_counters("t5");

        // 6: reset asserted mid-payload
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(8'(i + 8'h10), 1'b1, 1'b0);
        end
        tick();
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(stream_if.out_valid), 32'd0);
        check("t6_rst_last", 32'(stream_if.out_last), 32'd0);
        check("t6_rst_data", 32'(stream_if.out_data), 32'd0);
        check("t6_rst_ok", 32'(frames_ok), 32'd0);
        check("t6_rst_drop", 32'(frames_drop), 32'd0);
        dv = 1'b0;
        rxd = 8'h00;
        exp_ok = 0;
        exp_drop = 0;
        exp_wr_ptr = '0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        send_frame(60, 8'h33, -1, 1'b0, 1'b1);
        wait_drain("t6", 2000);
        check_counters("t6");
        check("t6_wr_ptr", 32'(dut.wr_ptr), 32'(exp_wr_ptr));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
